// File: rtl/usbreceiver_pkg.sv
// -----------------------------------------------------------------------------
// usbreceiver_pkg
// Shared definitions for the FT2232/FT245 asynchronous receive path:
//   - default FT2232 timing cycle counts at a 60 MHz mclk
//   - default FIFO depth (log2)
//   - 2-bit receive FSM state encoding
//   - small constant helper used to size counters
// No ports (package).
// -----------------------------------------------------------------------------
package usbreceiver_pkg;

  // RD# low time: 4 cycles of 16.7 ns covers the >=50 ns RD# pulse width.
  localparam int unsigned FT_RD_PULSE_CYCLES = 4;
  // RXF# is not trusted for this many cycles after RD# rises.
  localparam int unsigned FT_RECOVER_CYCLES  = 5;
  // 2 KiB receive FIFO by default.
  localparam int unsigned FT_FIFO_LOG_SIZE   = 11;
  localparam int unsigned BYTE_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RECOVER = 2'd3
  } rx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usbreceiver_if.sv
// -----------------------------------------------------------------------------
// usbreceiver_if
// Valid/ready byte stream between the receiver and fabric logic.
//   data  : head byte of the stream      (master -> slave)
//   valid : data is valid                (master -> slave)
//   ready : consumer accepts the byte    (slave  -> master)
// A transfer happens on a clock edge where valid && ready.
// -----------------------------------------------------------------------------
interface usbreceiver_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/usbreceiver_bram_fifo_sdp.sv
// -----------------------------------------------------------------------------
// bram_fifo_sdp
// Simple dual-port memory intended for block-RAM inference: one write port and
// one synchronous (registered) read port on the same clock. The read data
// register has no reset so the tools can map it onto the BRAM output latch.
// Ports:
//   clk        : clock
//   wr_en_i    : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read enable, loads rd_data_o on the next edge
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
// -----------------------------------------------------------------------------
module bram_fifo_sdp #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/usbreceiver.sv
// -----------------------------------------------------------------------------
// usbreceiver
// Host->FPGA half of the FT2232/FT245 asynchronous FIFO link. While RXF# says
// a byte is waiting, pulses RD# low, samples usb_d on the last low cycle,
// stores the byte in a BRAM FIFO and streams it out through a show-ahead
// output register. This block never drives usb_d.
// Ports:
//   mclk       : sole clock, rising edge
//   reset      : synchronous active-high reset
//   usb_d      : FT2232 data bus (input-only view)
//   usb_rxf_n  : FT2232 RXF#, asynchronous, low = byte available
//   usb_rd_n   : FT2232 RD#, registered
//   usb_oe_n   : tied high (async FIFO mode)
//   out_if     : valid/ready byte stream (master side)
//   fifo_full  : no free FIFO entry
//   fifo_empty : FIFO memory holds no bytes (output register may still be valid)
//   overrun    : sticky, a sampled byte found the FIFO full
// -----------------------------------------------------------------------------
module usbreceiver
  import usbreceiver_pkg::*;
#(
  parameter int unsigned RD_PULSE_CYCLES = FT_RD_PULSE_CYCLES,
  parameter int unsigned RECOVER_CYCLES  = FT_RECOVER_CYCLES,
  parameter int unsigned FIFO_LOG_SIZE   = FT_FIFO_LOG_SIZE
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] usb_d,
  input  logic              usb_rxf_n,
  output logic              usb_rd_n,
  output logic              usb_oe_n,
  usbreceiver_if.master     out_if,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(max_u(RD_PULSE_CYCLES, RECOVER_CYCLES) + 1);
  localparam logic [CNT_W-1:0]         CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]         RD_LAST      = CNT_W'(RD_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [FIFO_LOG_SIZE-1:0] PTR_ONE      = FIFO_LOG_SIZE'(1);

  logic                     rxf_meta_q;
  logic                     rxf_s_q;
  rx_state_e                state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     rd_n_q;
  logic [BYTE_W-1:0]        rx_byte_q;
  logic [FIFO_LOG_SIZE-1:0] wr_ptr_q;
  logic [FIFO_LOG_SIZE-1:0] rd_ptr_q;
  logic                     out_valid_q;
  logic                     overrun_q;

  logic                     full_s;
  logic                     empty_s;
  logic                     wr_en_s;
  logic                     load_s;
  logic [BYTE_W-1:0]        rd_data_s;

  // Flags come from the pre-edge pointers; one slot is sacrificed to tell
  // full from empty.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = ((wr_ptr_q + PTR_ONE) == rd_ptr_q);

  // A full FIFO at write time means the byte has nowhere to go: drop it.
  assign wr_en_s = (state_q == ST_WRITE) && !full_s;

  // Show-ahead: refill the output register whenever it is empty or being
  // consumed this cycle.
  assign load_s  = !empty_s && (!out_valid_q || out_if.ready);

  // Two-flop synchroniser for the asynchronous RXF# pin.
  always_ff @(posedge mclk) begin
    if (reset) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
    end else begin
      rxf_meta_q <= usb_rxf_n;
      rxf_s_q    <= rxf_meta_q;
    end
  end

  // Read-strobe FSM, RD# generation, byte capture and write pointer.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_n_q    <= 1'b1;
      wr_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Leave the byte in the FT2232 while there is no room for it.
          if (!rxf_s_q && !full_s) begin
            state_q <= ST_STROBE;
            rd_n_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_STROBE: begin
          if (cnt_q == RD_LAST) begin
            rx_byte_q <= usb_d;
            rd_n_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_WRITE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WRITE: begin
          if (full_s) begin
            overrun_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
          end
          cnt_q   <= '0;
          state_q <= ST_RECOVER;
        end
        ST_RECOVER: begin
          // RXF# may still read low from the byte just taken; ignore it here.
          if (cnt_q == RECOVER_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_n_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Read pointer and output-valid flag of the show-ahead register.
  always_ff @(posedge mclk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (load_s) begin
      rd_ptr_q    <= rd_ptr_q + PTR_ONE;
      out_valid_q <= 1'b1;
    end else if (out_if.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // The BRAM read register doubles as the output data register.
  bram_fifo_sdp #(
    .ADDR_W (FIFO_LOG_SIZE),
    .DATA_W (BYTE_W)
  ) u_fifo_mem (
    .clk       (mclk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rx_byte_q),
    .rd_en_i   (load_s && !reset),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data_s)
  );

  assign usb_rd_n     = rd_n_q;
  assign usb_oe_n     = 1'b1;
  assign out_if.data  = rd_data_s;
  assign out_if.valid = out_valid_q;
  assign fifo_full    = full_s;
  assign fifo_empty   = empty_s;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_usbreceiver.sv
// -----------------------------------------------------------------------------
// tb_usbreceiver
// Self-checking bench for usbreceiver (8-entry FIFO, default FT2232 timing).
// A host model holds bytes for the FT2232 and releases one per completed RD#
// pulse; every byte it hands over is expected back on the stream, in order.
// -----------------------------------------------------------------------------
module tb_usbreceiver;

  logic       mclk = 1'b0;
  logic       reset;
  logic [7:0] usb_d;
  logic       usb_rxf_n;
  logic       usb_rd_n;
  logic       usb_oe_n;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overrun;

  usbreceiver_if sif ();

  usbreceiver #(
    .RD_PULSE_CYCLES (4),
    .RECOVER_CYCLES  (5),
    .FIFO_LOG_SIZE   (3)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .usb_d      (usb_d),
    .usb_rxf_n  (usb_rxf_n),
    .usb_rd_n   (usb_rd_n),
    .usb_oe_n   (usb_oe_n),
    .out_if     (sif),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overrun    (overrun)
  );

  always #5 mclk = ~mclk;

  localparam int RD_W      = 4;
  localparam int BYTE_GAP  = 11;   // 4 low + 5 recover + 2
  localparam int MIN_HIGH  = 7;

  int vectors     = 0;
  int miscompares = 0;

  // host / scoreboard model
  logic [7:0] host_q[$];
  logic [7:0] exp_q[$];
  int   glitch      = 0;
  int   cyc         = 0;
  int   strobes     = 0;
  int   delivered   = 0;
  int   low_len     = 0;
  int   high_len    = 0;
  int   last_fall   = -1;
  bit   spacing_en  = 1'b0;
  int   strobe_while_full = 0;
  logic prev_rd_n   = 1'b1;
  logic prev_full   = 1'b0;

  typedef struct {
    int n_bytes;
    bit seq_data;
    int ready_mode;     // 0 always, 1 never, 2 toggle, 3 random
    int stall_cycles;   // ready held low this long first
    bit spacing;
    int exp_stall_strobes;
    bit exp_stall_full;
  } scen_t;

  scen_t scen[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe on the falling edge, then drive the next inputs.
  task automatic tick(input int mode);
    logic rdy;
    @(negedge mclk);
    cyc++;
    if (prev_rd_n === 1'b1 && usb_rd_n === 1'b0) begin
      if (prev_full === 1'b1) strobe_while_full++;
      if (last_fall >= 0) check("rd_high_gap_min", (high_len >= MIN_HIGH), 1);
      if (spacing_en && last_fall >= 0) check("strobe_spacing", cyc - last_fall, BYTE_GAP);
      last_fall = cyc;
      low_len   = 0;
    end
    if (usb_rd_n === 1'b0) low_len++;
    if (usb_rd_n === 1'b1) high_len++;
    if (prev_rd_n === 1'b0 && usb_rd_n === 1'b1) begin
      high_len = 1;
      if (host_q.size() > 0) void'(host_q.pop_front());
      if (reset) begin
        exp_q.delete();
      end else begin
        check("rd_low_width", low_len, RD_W);
        strobes++;
      end
    end
    prev_rd_n = usb_rd_n;
    prev_full = fifo_full;
    usb_d     = (host_q.size() > 0) ? host_q[0] : 8'($urandom_range(0, 255));
    usb_rxf_n = !(host_q.size() > 0 || glitch > 0);
    if (glitch > 0) glitch--;
    case (mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'b0;
      2:       rdy = cyc[0];
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    if (sif.valid === 1'b1 && rdy) begin
      if (exp_q.size() == 0) check("spurious_output", 1, 0);
      else check("stream_byte", sif.data, exp_q.pop_front());
      delivered++;
    end
    sif.ready = rdy;
  endtask

  task automatic clear_model();
    host_q.delete();
    exp_q.delete();
    strobes = 0; delivered = 0; last_fall = -1; high_len = 0;
    strobe_while_full = 0; spacing_en = 1'b0; glitch = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick(1);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic push(input logic [7:0] b);
    host_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic run_until(input int n, input int mode, input int budget);
    int c = 0;
    while (delivered < n && c < budget) begin
      tick(mode);
      c++;
    end
    check("delivered_count", delivered, n);
  endtask

  task automatic idle_checks();
    repeat (5) tick(0);
    check("overrun_clear", overrun, 0);
    check("drained_empty", fifo_empty, 1);
    check("drained_valid", sif.valid, 0);
    check("nothing_left", exp_q.size(), 0);
  endtask

  initial begin
    reset     = 1'b1;
    usb_rxf_n = 1'b1;
    usb_d     = 8'h00;
    sif.ready = 1'b0;

    scen[0] = '{n_bytes: 64, seq_data: 1'b1, ready_mode: 0, stall_cycles: 0,
                spacing: 1'b1, exp_stall_strobes: 0, exp_stall_full: 1'b0};
    scen[1] = '{n_bytes: 20, seq_data: 1'b0, ready_mode: 0, stall_cycles: 150,
                spacing: 1'b0, exp_stall_strobes: 8, exp_stall_full: 1'b1};
    scen[2] = '{n_bytes: 40, seq_data: 1'b0, ready_mode: 2, stall_cycles: 0,
                spacing: 1'b0, exp_stall_strobes: 0, exp_stall_full: 1'b0};
    scen[3] = '{n_bytes: 30, seq_data: 1'b0, ready_mode: 3, stall_cycles: 0,
                spacing: 1'b0, exp_stall_strobes: 0, exp_stall_full: 1'b0};

    // reset state
    do_reset();
    check("rst_rd_n", usb_rd_n, 1);
    check("rst_oe_n", usb_oe_n, 1);
    check("rst_valid", sif.valid, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_overrun", overrun, 0);

    // single byte: exact RD# timing and output latency
    push(8'hA5);
    tick(1);                       // RXF# falls here (k = 0)
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      check("single_rd_n", usb_rd_n, (k >= 3 && k <= 6) ? 0 : 1);
      check("single_valid", sif.valid, (k >= 9) ? 1 : 0);
      if (k >= 9) check("single_data", sif.data, 8'hA5);
    end
    check("single_no_second_strobe", strobes, 1);
    run_until(1, 0, 10);
    idle_checks();

    // table-driven scenarios
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < scen[s].n_bytes; i++)
        push(scen[s].seq_data ? 8'(i) : 8'($urandom_range(0, 255)));
      spacing_en = scen[s].spacing;
      if (scen[s].stall_cycles > 0) begin
        repeat (scen[s].stall_cycles) tick(1);
        check("stall_strobes", strobes, scen[s].exp_stall_strobes);
        check("stall_full", fifo_full, scen[s].exp_stall_full);
        check("stall_valid", sif.valid, 1);
        check("stall_rd_n", usb_rd_n, 1);
        check("strobe_while_full", strobe_while_full, 0);
      end
      run_until(scen[s].n_bytes, scen[s].ready_mode, scen[s].n_bytes * 2 * BYTE_GAP + 300);
      check("scen_strobes", strobes, scen[s].n_bytes);
      idle_checks();
    end

    // reset in the second STROBE cycle
    do_reset();
    push(8'h77);
    begin
      int c = 0;
      while (usb_rd_n !== 1'b0 && c < 20) begin tick(1); c++; end
      check("abort_strobe_seen", usb_rd_n, 0);
    end
    tick(1);                       // second STROBE cycle
    reset = 1'b1;
    tick(1);
    check("abort_rd_n", usb_rd_n, 1);
    check("abort_valid", sif.valid, 0);
    check("abort_empty", fifo_empty, 1);
    reset = 1'b0;
    clear_model();
    repeat (5) tick(1);
    check("abort_no_restrobe", strobes, 0);
    push(8'h3C);
    run_until(1, 0, 40);
    idle_checks();

    // one-cycle RXF# glitch while recovering
    do_reset();
    push(8'h5A);
    begin
      int c = 0;
      while (strobes == 0 && c < 40) begin tick(1); c++; end
      check("glitch_first_strobe", strobes, 1);
    end
    tick(1);
    glitch = 1;
    repeat (30) tick(0);
    check("glitch_no_strobe", strobes, 1);
    check("glitch_delivered", delivered, 1);
    idle_checks();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
